cpu65xx_status_register: RTL
============================

Name: cpu65xx_status_register

Overview:
Processor status register (P) for the 65xx core. It sits directly downstream of the ALU and captures the carry, zero, negative and overflow flags the ALU produces, under per-flag update enables from microcode. It also handles the explicit flag instructions (CLC/SEC/CLI/SEI/CLD/SED/CLV), PLP/RTI loads, interrupt entry and PHP/BRK push formatting. It returns carry, overflow and decimal to the ALU inputs and provides the delayed IRQ mask to the interrupt logic.

Parameters:
CMOS, 0, 1 = 65C02 behaviour: interrupt entry clears D. 0 = NMOS: D is untouched on interrupt entry.

Ports:
clk  input  1  core clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
aluCarry  input  1  ALU carryOut
aluZero  input  1  ALU zero
aluNegative  input  1  ALU negative
aluOverflow  input  1  ALU overflowOut
updateC  input  1  write C from aluCarry this cycle
updateZ  input  1  write Z from aluZero this cycle
updateN  input  1  write N from aluNegative this cycle
updateV  input  1  write V from aluOverflow this cycle
flagWrite  input  1  explicit set/clear of one flag
flagIndex  input  3  bit index in P for flagWrite (0=C,1=Z,2=I,3=D,6=V,7=N)
flagValue  input  1  value written by flagWrite
loadP  input  1  load P from dataIn (PLP/RTI pull)
dataIn  input  8  pulled status byte
intEntry  input  1  interrupt/BRK entry: set I; clear D if CMOS
instrBoundary  input  1  high for one cycle at each opcode fetch (sync)
pushBreak  input  1  B bit value for stackOut (1 = PHP/BRK, 0 = IRQ/NMI)
status  output  8  P view: {N,V,1,1,D,I,Z,C}
stackOut  output  8  push byte: {N,V,1,pushBreak,D,I,Z,C}
carry  output  1  C, to ALU carryIn
overflow  output  1  V, to ALU overflowIn
decimal  output  1  D, to ALU decimalMode
irqMask  output  1  effective IRQ mask used by interrupt polling

Behaviour:
- State: six flag flops (N,V,D,I,Z,C) plus the irqMask flop. Bits 5 and 4 are not stored; status always reads them as 1. stackOut is combinational from the flops.
- Reset (clk edge with reset=1): N=V=Z=C=0, D=0, I=1, irqMask=1. Reset overrides every other input in the same cycle. Reset asserted mid-instruction discards any pending update.
- Per-flag next-state priority, highest first:
  1. reset.
  2. intEntry: acts on I and, if CMOS=1, on D. All other flags follow the rules below.
  3. loadP: all six flags <= dataIn bits 7,6,3,2,1,0. dataIn bits 5 and 4 are ignored. While loadP=1, ALU updates and flagWrite are ignored.
  4. flagWrite: writes only P[flagIndex] <= flagValue. flagIndex 4 or 5 is a no-op.
  5. updateX: writes the matching ALU flag.
  6. Otherwise hold.
- A flagWrite and an updateX may be active in the same cycle. They merge per bit: the flagWrite target bit takes flagValue; every other enabled bit takes its ALU value.
- If intEntry and loadP are both high, loadP is applied first and then intEntry overrides I (and D when CMOS=1).
- All updates have 1-cycle latency. carry, overflow and decimal reflect the new value in the cycle after the write edge. There is no bypass.
- irqMask: on a clk edge with instrBoundary=1, irqMask <= the I value registered before that edge.
  - Effect: an I change made by CLI, SEI or PLP reaches irqMask only at the following opcode fetch. The instruction after CLI therefore still runs masked, matching 6502 timing.
  - Exception: intEntry sets irqMask=1 on the same edge it sets I, so nested IRQs are blocked immediately.
- If instrBoundary and a flag update fall on the same edge, irqMask takes the old I and the flag takes its new value.
- RTI (loadP) takes effect in irqMask at the next instrBoundary, like PLP.

Test Plan:
- Reset: hold reset 2 cycles -> status=8'h34, irqMask=1, carry=0, decimal=0.
- ALU update with mask: updateZ=updateN=1, aluZero=1, aluNegative=1, aluCarry=1, updateC=0 -> next cycle status=8'hB6, carry unchanged at 0.
- Merged write: flagWrite idx0 value1 together with updateZ=1, aluZero=0, starting from status=8'h36 -> next cycle status=8'h35.
- PLP: loadP=1, dataIn=8'hCB, updateC=1, aluCarry=0 -> status=8'hFB (C=1 from dataIn), stackOut with pushBreak=0 = 8'hEB.
- CLI latency: from I=1, flagWrite idx2 value0 -> I=0 next cycle, irqMask stays 1 until the first instrBoundary edge, then 0.
- Interrupt entry: D=1, I=0, intEntry=1 -> CMOS=0 gives status=8'h3C; CMOS=1 gives status=8'h34; irqMask=1 on the same edge in both cases.

Source files
------------

// File: rtl/cpu65xx_status_register.sv
// 65xx processor status register (P): ALU flag capture, explicit flag ops,
// PLP/RTI loads, interrupt entry, push formatting and delayed IRQ mask.
module cpu65xx_status_register #(
    parameter bit CMOS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       aluCarry,
    input  logic       aluZero,
    input  logic       aluNegative,
    input  logic       aluOverflow,
    input  logic       updateC,
    input  logic       updateZ,
    input  logic       updateN,
    input  logic       updateV,
    input  logic       flagWrite,
    input  logic [2:0] flagIndex,
    input  logic       flagValue,
    input  logic       loadP,
    input  logic [7:0] dataIn,
    input  logic       intEntry,
    input  logic       instrBoundary,
    input  logic       pushBreak,
    output logic [7:0] status,
    output logic [7:0] stackOut,
    output logic       carry,
    output logic       overflow,
    output logic       decimal,
    output logic       irqMask
);

    logic n_q, v_q, d_q, i_q, z_q, c_q, irq_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d, irq_d;

    always_comb begin
        n_d   = n_q;
        v_d   = v_q;
        d_d   = d_q;
        i_d   = i_q;
        z_d   = z_q;
        c_d   = c_q;
        irq_d = irq_q;
        if (loadP) begin
            n_d = dataIn[7];
            v_d = dataIn[6];
            d_d = dataIn[3];
            i_d = dataIn[2];
            z_d = dataIn[1];
            c_d = dataIn[0];
        end else begin
            if (updateC) c_d = aluCarry;
            if (updateZ) z_d = aluZero;
            if (updateN) n_d = aluNegative;
            if (updateV) v_d = aluOverflow;
            // Explicit write wins over the ALU on its target bit only
            if (flagWrite) begin
                case (flagIndex)
                    3'd0:    c_d = flagValue;
                    3'd1:    z_d = flagValue;
                    3'd2:    i_d = flagValue;
                    3'd3:    d_d = flagValue;
                    3'd6:    v_d = flagValue;
                    3'd7:    n_d = flagValue;
                    default: ;
                endcase
            end
        end
        if (intEntry) begin
            i_d = 1'b1;
            if (CMOS) d_d = 1'b0;
        end
        // Mask follows the old I at opcode fetch; entry masks immediately
        if (intEntry) begin
            irq_d = 1'b1;
        end else if (instrBoundary) begin
            irq_d = i_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q   <= 1'b0;
            v_q   <= 1'b0;
            d_q   <= 1'b0;
            i_q   <= 1'b1;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            irq_q <= 1'b1;
        end else begin
            n_q   <= n_d;
            v_q   <= v_d;
            d_q   <= d_d;
            i_q   <= i_d;
            z_q   <= z_d;
            c_q   <= c_d;
            irq_q <= irq_d;
        end
    end

    assign status   = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign stackOut = {n_q, v_q, 1'b1, pushBreak, d_q, i_q, z_q, c_q};
    assign carry    = c_q;
    assign overflow = v_q;
    assign decimal  = d_q;
    assign irqMask  = irq_q;

endmodule
